// File: rtl/sl_receiver_if.sv
// ---------------------------------------------------------------------------
// sl_receiver_if -- bus bundle for the SL line receiver.
//
// Signals:
//   sl0, sl1          SL line pair (idle = both high, bit 0 = sl0 low only,
//                     bit 1 = sl1 low only, stop = both low)
//   wr_config_w       configuration word {freq_mode[2:0], reserved, length[5:0]}
//   wr_config_enable  load wr_config_w on this clock edge
//   r_config_w        configuration readback, reserved bit reads 0
//   data_out          last received data word, right-aligned
//   bit_count         number of data bits in the last word (parity excluded)
//   word_ready        one-cycle pulse when a word has been received
//   rx_error          one-cycle pulse on a framing error
//   parity_valid      odd parity held for the last word
//   length_valid      last word length matched the configured length
//   word_in_process   a frame is currently being received
//
// Modports: master drives the line and configuration, slave is the receiver.
// ---------------------------------------------------------------------------
interface sl_receiver_if;
   logic        sl0;
   logic        sl1;
   logic [9:0]  wr_config_w;
   logic        wr_config_enable;
   logic [9:0]  r_config_w;
   logic [31:0] data_out;
   logic [5:0]  bit_count;
   logic        word_ready;
   logic        rx_error;
   logic        parity_valid;
   logic        length_valid;
   logic        word_in_process;

   modport master (
      output sl0, sl1, wr_config_w, wr_config_enable,
      input  r_config_w, data_out, bit_count, word_ready, rx_error,
             parity_valid, length_valid, word_in_process
   );

   modport slave (
      input  sl0, sl1, wr_config_w, wr_config_enable,
      output r_config_w, data_out, bit_count, word_ready, rx_error,
             parity_valid, length_valid, word_in_process
   );
endinterface

// File: rtl/sl_receiver.sv
// ---------------------------------------------------------------------------
// sl_receiver -- receiver for a two-wire SL symbol line.
//
// Each symbol is a bit pattern on the line (sl0 low = 0, sl1 low = 1)
// separated by idle; a stop pattern (both low) closes the frame. The last
// symbol of a frame is an odd-parity bit, the rest are data, first symbol
// most significant.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   sl_receiver_if.slave (line inputs, config, result outputs)
//
// Optional feature: define SL_RX_TIMEOUT_EN to abort a frame that sees no
// accepted line change for 16 << freq_mode cycles. Without it freq_mode is
// only stored and read back.
// ---------------------------------------------------------------------------
module sl_receiver (
   input logic          clk,
   input logic          rst,
   sl_receiver_if.slave bus
);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SYMBOL, RELEASE} state_t;

   // Line patterns as {sl1, sl0}
   localparam logic [1:0] PAT_IDLE = 2'b11;
   localparam logic [1:0] PAT_BIT0 = 2'b10;
   localparam logic [1:0] PAT_BIT1 = 2'b01;
   localparam logic [1:0] PAT_STOP = 2'b00;

   state_t      state;
   logic [1:0]  sync_a;      // first synchronizer stage
   logic [1:0]  sync_b;      // second synchronizer stage
   logic [1:0]  sync_c;      // previous synchronized sample, for acceptance
   logic [32:0] shift;       // symbols, first received ends up most significant
   logic [5:0]  count;       // symbols received in the current frame
   logic [2:0]  freq_mode;
   logic [5:0]  length;

   logic        stable;
   logic [1:0]  pat;
   logic        is_idle;
   logic        is_bit;
   logic        is_stop;
   logic        bit_val;
   logic        do_symbol;
   logic        do_stop;
   logic        unused_reserved;

   // The reserved config bit is not stored.
   assign unused_reserved = bus.wr_config_w[6];

   // A pattern is accepted once two consecutive synchronized samples agree,
   // which filters single-cycle glitches.
   assign stable    = (sync_b == sync_c);
   assign pat       = sync_b;
   assign is_idle   = stable && (pat == PAT_IDLE);
   assign is_stop   = stable && (pat == PAT_STOP);
   assign is_bit    = stable && ((pat == PAT_BIT0) || (pat == PAT_BIT1));
   assign bit_val   = (pat == PAT_BIT1);

   // A new symbol is taken only after idle separated it from the previous one
   // (RELEASE blocks re-counting a held bit). Stop only counts once a symbol
   // has been seen.
   assign do_symbol = is_bit  && ((state == IDLE) || (state == SYMBOL));
   assign do_stop   = is_stop && ((state == SYMBOL) || (state == RELEASE));

   assign bus.r_config_w = {freq_mode, 1'b0, length};

`ifdef SL_RX_TIMEOUT_EN
   logic [1:0]  last_pat;
   logic [11:0] quiet_cycles;
   logic [11:0] timeout_limit;
   logic        pat_change;

   assign timeout_limit = 12'd16 << freq_mode;
   assign pat_change    = stable && (pat != last_pat);
`endif

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values of the others; reset is synchronous, so it
   // sits inside the clocked block rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= WAIT_IDLE;
         sync_a               <= PAT_IDLE;
         sync_b               <= PAT_IDLE;
         sync_c               <= PAT_IDLE;
         shift                <= '0;
         count                <= '0;
         freq_mode            <= 3'd0;
         length               <= 6'd32;
         bus.data_out         <= '0;
         bus.bit_count        <= '0;
         bus.word_ready       <= 1'b0;
         bus.rx_error         <= 1'b0;
         bus.parity_valid     <= 1'b0;
         bus.length_valid     <= 1'b0;
         bus.word_in_process  <= 1'b0;
`ifdef SL_RX_TIMEOUT_EN
         last_pat             <= PAT_IDLE;
         quiet_cycles         <= '0;
`endif
      end else begin
         sync_a         <= {bus.sl1, bus.sl0};
         sync_b         <= sync_a;
         sync_c         <= sync_b;
         bus.word_ready <= 1'b0;
         bus.rx_error   <= 1'b0;

         if (bus.wr_config_enable) begin
            freq_mode <= bus.wr_config_w[9:7];
            length    <= bus.wr_config_w[5:0];
         end

         if (state == WAIT_IDLE) begin
            if (is_idle) begin
               state <= IDLE;
               shift <= '0;
               count <= '0;
            end
         end else if (do_symbol) begin
            if (count == 6'd33) begin
               // 34th symbol: frame too long, drop it
               bus.rx_error        <= 1'b1;
               bus.word_in_process <= 1'b0;
               state               <= WAIT_IDLE;
            end else begin
               shift               <= {shift[31:0], bit_val};
               count               <= count + 6'd1;
               bus.word_in_process <= 1'b1;
               state               <= RELEASE;
            end
         end else if (do_stop) begin
            if (count >= 6'd2) begin
               // Drop the parity symbol; the shift register was cleared at
               // frame start, so the upper bits are already zero.
               bus.data_out     <= shift[32:1];
               bus.bit_count    <= count - 6'd1;
               bus.parity_valid <= ^shift;
               bus.length_valid <= ((count - 6'd1) == length);
               bus.word_ready   <= 1'b1;
            end else begin
               // A lone parity symbol carries no data
               bus.rx_error     <= 1'b1;
            end
            bus.word_in_process <= 1'b0;
            state               <= WAIT_IDLE;
         end else if ((state == RELEASE) && is_idle) begin
            state <= SYMBOL;
         end

`ifdef SL_RX_TIMEOUT_EN
         if (stable)
            last_pat <= pat;
         // Only a quiet line (no accepted change) ever reaches the abort,
         // so it never competes with a symbol or stop taken above.
         if ((state == SYMBOL) || (state == RELEASE)) begin
            if (pat_change) begin
               quiet_cycles <= '0;
            end else if (quiet_cycles == timeout_limit - 12'd1) begin
               bus.rx_error        <= 1'b1;
               bus.word_in_process <= 1'b0;
               state               <= WAIT_IDLE;
               quiet_cycles        <= '0;
            end else begin
               quiet_cycles <= quiet_cycles + 12'd1;
            end
         end else begin
            quiet_cycles <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sl_receiver.sv
// ---------------------------------------------------------------------------
// tb_sl_receiver -- self-checking bench for sl_receiver.
// Frames are built as symbol lists; expected results are computed from the
// list with plain arithmetic (data value, count of ones, length compare).
// ---------------------------------------------------------------------------
module tb_sl_receiver;

   localparam logic [1:0] PAT_IDLE = 2'b11;
   localparam logic [1:0] PAT_BIT0 = 2'b10;
   localparam logic [1:0] PAT_BIT1 = 2'b01;
   localparam logic [1:0] PAT_STOP = 2'b00;

   logic clk = 1'b0;
   logic rst;

   sl_receiver_if bus ();

   sl_receiver dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int err_cnt = 0;

   // Reference state: last successful word and current configuration
   logic [31:0] exp_data;
   int          exp_bits;
   int          exp_par;
   int          exp_len;
   int          cfg_len;
   bit          sym_q[$];

   // Pulse counters, sampled just after each active edge
   always @(posedge clk) begin
      #1;
      if (bus.word_ready === 1'b1) wr_cnt++;
      if (bus.rx_error   === 1'b1) err_cnt++;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic line(input logic [1:0] p, input int n);
      {bus.sl1, bus.sl0} = p;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_symbol(input bit b);
      line(b ? PAT_BIT1 : PAT_BIT0, 4);
      line(PAT_IDLE, 4);
   endtask

   task automatic set_config(input logic [2:0] fm, input logic [5:0] len);
      bus.wr_config_w      = {fm, 1'b1, len};
      bus.wr_config_enable = 1'b1;
      @(negedge clk);
      bus.wr_config_enable = 1'b0;
      cfg_len = int'(len);
      check("r_config", {22'd0, bus.r_config_w}, {22'd0, fm, 1'b0, len});
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_data"},   bus.data_out, exp_data);
      check({tag, "_bits"},   {26'd0, bus.bit_count}, exp_bits);
      check({tag, "_parity"}, {31'd0, bus.parity_valid}, exp_par);
      check({tag, "_lenok"},  {31'd0, bus.length_valid}, exp_len);
      check({tag, "_wip"},    {31'd0, bus.word_in_process}, 0);
   endtask

   // Send sym_q as a frame followed by stop, then check against the model.
   task automatic send_frame(input string tag);
      int     n, wr0, er0, ones;
      logic   r3, r4;
      longint d;
      n   = sym_q.size();
      wr0 = wr_cnt;
      er0 = err_cnt;
      foreach (sym_q[i]) send_symbol(sym_q[i]);
      {bus.sl1, bus.sl0} = PAT_STOP;
      r3 = 1'b0;
      r4 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         if (k == 3) r3 = bus.word_ready;
         if (k == 4) r4 = bus.word_ready;
      end
      @(negedge clk);
      repeat (4) @(negedge clk);
      line(PAT_IDLE, 4);
      if (n >= 2 && n <= 33) begin
         d    = 0;
         ones = 0;
         for (int i = 0; i < n; i++) begin
            ones += int'(sym_q[i]);
            if (i < n - 1) d = d * 2 + longint'(sym_q[i]);
         end
         exp_data = d[31:0];
         exp_bits = n - 1;
         exp_par  = ones % 2;
         exp_len  = (exp_bits == cfg_len) ? 1 : 0;
         check({tag, "_ready_cnt"}, wr_cnt - wr0, 1);
         check({tag, "_err_cnt"},   err_cnt - er0, 0);
         check({tag, "_ready_e3"},  {31'd0, r3}, 0);
         check({tag, "_ready_e4"},  {31'd0, r4}, 1);
      end else begin
         check({tag, "_ready_cnt"}, wr_cnt - wr0, 0);
         check({tag, "_err_cnt"},   err_cnt - er0, 1);
      end
      check_outputs(tag);
   endtask

   task automatic load_word(input logic [31:0] data, input int nb, input bit par);
      sym_q.delete();
      for (int i = nb - 1; i >= 0; i--) sym_q.push_back(data[i]);
      sym_q.push_back(par);
   endtask

   task automatic model_reset();
      exp_data = '0;
      exp_bits = 0;
      exp_par  = 0;
      exp_len  = 0;
      cfg_len  = 32;
   endtask

   initial begin
      int          wr0, er0, nb;
      logic [31:0] data, mask;
      logic [5:0]  len;

      rst                  = 1'b1;
      bus.sl0              = 1'b1;
      bus.sl1              = 1'b1;
      bus.wr_config_w      = '0;
      bus.wr_config_enable = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset");
      check("reset_ready", {31'd0, bus.word_ready}, 0);
      check("reset_error", {31'd0, bus.rx_error}, 0);
      check("reset_config", {22'd0, bus.r_config_w}, 32'h020);
      rst = 1'b0;
      line(PAT_IDLE, 4);

      // Single-cycle glitch in IDLE must not start a frame
      wr0 = wr_cnt;
      er0 = err_cnt;
      line(PAT_BIT0, 1);
      line(PAT_IDLE, 6);
      check("glitch_wip", {31'd0, bus.word_in_process}, 0);
      check("glitch_pulses", (wr_cnt - wr0) + (err_cnt - er0), 0);

      // 0xA5 with parity 1, length 8
      set_config(3'd0, 6'd8);
      load_word(32'hA5, 8, 1'b1);
      send_frame("a5");

      // 0xDEADBEEF with a wrong (even) parity bit
      set_config(3'd0, 6'd32);
      load_word(32'hDEADBEEF, 32, 1'b0);
      send_frame("deadbeef");

      // Stop in IDLE is ignored
      wr0 = wr_cnt;
      er0 = err_cnt;
      line(PAT_STOP, 6);
      line(PAT_IDLE, 6);
      check("idle_stop_pulses", (wr_cnt - wr0) + (err_cnt - er0), 0);

      // Random frames
      for (int t = 0; t < 5; t++) begin
         nb   = $urandom_range(1, 32);
         mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
         data = $urandom & mask;
         len  = $urandom_range(0, 1) ? 6'(nb) : 6'($urandom_range(0, 63));
         set_config(3'($urandom_range(0, 7)), len);
         load_word(data, nb, 1'($urandom_range(0, 1)));
         send_frame($sformatf("rand%0d", t));
      end

      // Stop after a single symbol: error, outputs unchanged
      sym_q.delete();
      sym_q.push_back(1'b1);
      send_frame("one_sym");

      // 34 symbols: error at the 34th, then a good 8-bit frame
      sym_q.delete();
      for (int i = 0; i < 34; i++) sym_q.push_back(1'($urandom_range(0, 1)));
      send_frame("sym34");
      set_config(3'd0, 6'd8);
      load_word(32'h3C, 8, 1'b0);
      send_frame("after34");

      // Reset after 5 symbols drops the frame silently
      wr0 = wr_cnt;
      er0 = err_cnt;
      for (int i = 0; i < 5; i++) send_symbol(1'($urandom_range(0, 1)));
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      check_outputs("midrst");
      check("midrst_config", {22'd0, bus.r_config_w}, 32'h020);
      rst = 1'b0;
      line(PAT_IDLE, 6);
      check("midrst_pulses", (wr_cnt - wr0) + (err_cnt - er0), 0);
      load_word(32'h0000_9ABC, 16, 1'b1);
      send_frame("after_rst");

      // Frame held in RELEASE for a long time with freq_mode = 2
      set_config(3'd2, 6'd32);
      er0 = err_cnt;
      send_symbol(1'b1);
      send_symbol(1'b0);
      line(PAT_BIT1, 90);
`ifdef SL_RX_TIMEOUT_EN
      check("timeout_err", err_cnt - er0, 1);
      check("timeout_wip", {31'd0, bus.word_in_process}, 0);
`else
      check("timeout_err", err_cnt - er0, 0);
      check("timeout_wip", {31'd0, bus.word_in_process}, 1);
`endif
      line(PAT_IDLE, 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      line(PAT_IDLE, 6);
      load_word(32'h5A, 8, 1'b0);
      send_frame("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sl_receiver.md
SL_RECEIVER -- requirements
Module: sl_receiver

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports sl0 and sl1, inputs, 1 bit each: SL line pair; idle = both high; bit 0 = sl0 low only; bit 1 = sl1 low only; stop = both low.
REQ-004 SHALL have port wr_config_w, input, 10 bits: {freq_mode[2:0], reserved, length[5:0]}.
REQ-005 SHALL have port wr_config_enable, input, 1 bit: load wr_config_w on this edge.
REQ-006 SHALL have port r_config_w, output, 10 bits: config readback; bit 6 reads 0.
REQ-007 SHALL have port data_out, output, 32 bits: last received data word, right-aligned.
REQ-008 SHALL have port bit_count, output, 6 bits: data bits in the last word, excluding parity.
REQ-009 SHALL have ports word_ready and rx_error, outputs, 1 bit each: one-cycle pulses.
REQ-010 SHALL have ports parity_valid, length_valid and word_in_process, outputs, 1 bit each: status levels.

Function
REQ-011 SHALL pass sl0/sl1 through a 2-flop synchronizer; a line pattern is accepted only when identical on 2 consecutive synchronized samples.
REQ-012 SHALL implement states WAIT_IDLE, IDLE, SYMBOL, RELEASE.
REQ-013 WAIT_IDLE SHALL go to IDLE on an accepted idle pattern; all other patterns are ignored.
REQ-014 IDLE or SYMBOL, on accepted bit 0 or bit 1: SHALL shift the bit into a 33-bit LSB-first register (first bit ends as MSB), increment the symbol counter, assert word_in_process, and enter RELEASE.
REQ-015 RELEASE SHALL return to SYMBOL only on an accepted idle pattern; a bit pattern while in RELEASE is the same symbol and SHALL NOT be counted again.
REQ-016 Accepted stop pattern with symbol count 2..33 SHALL present the result: data_out = the data symbols (all but the last, zero-extended); bit_count = symbols-1; parity_valid = 1 iff the XOR of all symbols is 1 (odd parity); length_valid = (bit_count == length).
REQ-017 With the REQ-016 result, SHALL pulse word_ready, clear word_in_process, and enter WAIT_IDLE.
REQ-018 word_ready SHALL rise on the 4th rising edge after the first edge at which both pins are low.
REQ-019 Stop in IDLE SHALL be ignored; stop with exactly 1 symbol SHALL pulse rx_error, keep data outputs unchanged, and go to WAIT_IDLE.
REQ-020 A 34th symbol SHALL pulse rx_error, discard the frame, and go to WAIT_IDLE.
REQ-021 data_out, bit_count, parity_valid and length_valid SHALL hold until the next successful stop.
REQ-022 wr_config_enable SHALL load the config in any state and take effect for the stop evaluated on the next edge or later; r_config_w = {freq_mode, 1'b0, length}.

Reset
REQ-023 rst SHALL force WAIT_IDLE, clear the shift register and counters, clear the synchronizers to 1, zero all outputs, and set config to freq_mode=0, length=32.
REQ-024 rst mid-frame SHALL drop the partial word with no word_ready or rx_error; reception restarts only after an accepted idle pattern.

Configuration
REQ-025 Macro SL_RX_TIMEOUT_EN defined: in SYMBOL/RELEASE, 16<<freq_mode cycles without an accepted pattern change SHALL pulse rx_error, discard the frame, and enter WAIT_IDLE; the counter restarts on every accepted change.
REQ-026 Macro SL_RX_TIMEOUT_EN undefined: no timeout logic; a frame stays open indefinitely; freq_mode is stored and read back only.

Verification
REQ-027 length=8, frame 0xA5 plus parity bit 1, stop -> data_out=0x000000A5, bit_count=8, parity_valid=1, length_valid=1, one word_ready pulse.
REQ-028 32 data bits 0xDEADBEEF with a wrong parity bit -> data_out=0xDEADBEEF, bit_count=32, parity_valid=0.
REQ-029 1-cycle low glitch on sl0 in IDLE -> no symbol counted, word_in_process stays 0.
REQ-030 34 symbols without stop -> rx_error pulse at the 34th; the next valid 8-bit frame is received correctly.
REQ-031 rst asserted after 5 symbols -> all outputs 0; the next 16-bit frame gives bit_count=16 and no rx_error.
REQ-032 With SL_RX_TIMEOUT_EN and freq_mode=2, line held in RELEASE for 64 cycles -> rx_error pulse, word_in_process=0; without the macro -> no error.
